write_ocm: RTL and testbench

Stream-to-memory writer on the Haddoc output side of the HPS system. It captures the classifier/feature-map byte stream qualified by `in_dv` and writes each valid byte to consecutive addresses of On-Chip RAM 1 (s2, write port). It then hands completion back to the HPS control logic with the same level-sensitive `start`/`finish` handshake the pixel reader uses. It also reports the word count and error conditions: overflow and stream timeout.

---
 rtl/write_ocm_pkg.sv | 13 +
 rtl/write_ocm_idle_timer.sv | 29 ++
 rtl/write_ocm.sv | 126 ++++++++++++
 tb/tb_write_ocm.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_ocm_pkg.sv
// Shared OCM definitions for the Haddoc stream reader/writer pair:
// FSM state encodings, image size and OCM address width.
package write_ocm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned OCM_ADDR_W = 17;

endpackage

// File: rtl/write_ocm_idle_timer.sv
// Saturating idle counter; expired flags the enabled cycle on whose edge
// the count reaches TIMEOUT.
module idle_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign expired = en && !clr && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/write_ocm.sv
// Stream-to-OCM writer: captures in_dv-qualified bytes into consecutive OCM1
// addresses and completes with the level-sensitive start/finish handshake.
module write_ocm
  import write_ocm_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = OCM_ADDR_W,
  parameter int unsigned NUM_WORDS = IMG_PIXELS,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dv,
  output logic [ADDR_W-1:0] ocm1_addr,
  output logic [DATA_W-1:0] ocm1_writedata,
  output logic              ocm1_chip,
  output logic              ocm1_clk_enab,
  output logic              ocm1_write,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              timeout
);

  logic [1:0]        r_state;
  logic              r_finish;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_strobe;
  logic [ADDR_W:0]   r_word_count;
  logic              r_overflow;
  logic              r_timeout;

  logic              w_timer_clr;
  logic              w_timer_en;
  logic              w_expired;
  logic [ADDR_W:0]   w_count_next;
  logic              w_last;
  logic [ADDR_W-1:0] w_wr_addr;

  // The timer only runs while capturing; any accepted byte restarts it.
  assign w_timer_clr  = (r_state != ST_CAPTURE) || in_dv;
  assign w_timer_en   = (r_state == ST_CAPTURE) && !in_dv;
  assign w_count_next = r_word_count + 1'b1;
  assign w_last       = (w_count_next == (ADDR_W+1)'(NUM_WORDS));
  assign w_wr_addr    = ADDR_W'(BASE_ADDR) + r_word_count[ADDR_W-1:0];

  idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_timer_clr),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_finish     <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_strobe     <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_finish <= 1'b0;
          if (start) begin
            r_state      <= ST_CAPTURE;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // Data takes priority over a coincident timer expiry.
          if (in_dv) begin
            r_strobe     <= 1'b1;
            r_addr       <= w_wr_addr;
            r_data       <= in_data;
            r_word_count <= w_count_next;
            if (w_last) r_state <= ST_FLUSH;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (in_dv) r_overflow <= 1'b1;
          r_finish <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (in_dv) r_overflow <= 1'b1;
          if (!start) begin
            r_state      <= ST_IDLE;
            r_finish     <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_word_count <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign finish         = r_finish;
  assign ocm1_addr      = r_addr;
  assign ocm1_writedata = r_data;
  assign ocm1_chip      = r_strobe;
  assign ocm1_clk_enab  = r_strobe;
  assign ocm1_write     = r_strobe;
  assign word_count     = r_word_count;
  assign overflow       = r_overflow;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_write_ocm.sv
// Self-checking bench for write_ocm: scenario tasks plus randomized runs
// checked against an arithmetic model of expected writes, flags and timing.
module tb_write_ocm;

  localparam int unsigned NUM  = 4;
  localparam int unsigned BASE = 32'h100;
  localparam int unsigned TO   = 8;
  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          finish;
  logic [DW-1:0] in_data;
  logic          in_dv;
  logic [AW-1:0] ocm1_addr;
  logic [DW-1:0] ocm1_writedata;
  logic          ocm1_chip;
  logic          ocm1_clk_enab;
  logic          ocm1_write;
  logic [AW:0]   word_count;
  logic          overflow;
  logic          timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int            e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t  wr_q[$];
  int   fin_edge = -1;
  int   to_edge  = -1;
  logic prev_fin = 1'b0;
  logic prev_to  = 1'b0;

  int            g_gap[16];
  logic [DW-1:0] g_dat[16];

  write_ocm #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_WORDS(NUM),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .finish        (finish),
    .in_data       (in_data),
    .in_dv         (in_dv),
    .ocm1_addr     (ocm1_addr),
    .ocm1_writedata(ocm1_writedata),
    .ocm1_chip     (ocm1_chip),
    .ocm1_clk_enab (ocm1_clk_enab),
    .ocm1_write    (ocm1_write),
    .word_count    (word_count),
    .overflow      (overflow),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every write strobe and the edge on which finish/timeout rose.
  always @(negedge clk) begin
    wr_t w;
    if (ocm1_write) begin
      w.e = cyc; w.a = ocm1_addr; w.d = ocm1_writedata;
      wr_q.push_back(w);
    end
    if (finish && !prev_fin && fin_edge < 0) fin_edge = cyc;
    if (timeout && !prev_to && to_edge < 0) to_edge = cyc;
    prev_fin = finish;
    prev_to  = timeout;
  end

  task automatic run_stream(input int n, input string name);
    wr_t  exp_q[$];
    int   last, e, k, exp_fin, exp_to, n_drive, budget;
    logic exp_ovf;
    logic hold_ovf, hold_to;
    wr_q.delete();
    fin_edge = -1;
    to_edge  = -1;
    @(negedge clk);
    start = 1'b1;
    in_dv = 1'b0;
    last = cyc + 1;
    k = 0; exp_fin = -1; exp_to = -1; exp_ovf = 1'b0; n_drive = n;
    for (int i = 0; i < n; i++) begin
      if (k == NUM) begin
        exp_ovf = 1'b1;
        continue;
      end
      if (g_gap[i] >= TO) begin
        n_drive = i;
        break;
      end
      e = last + g_gap[i] + 1;
      begin
        wr_t w;
        w.e = e; w.a = AW'(BASE + k); w.d = g_dat[i];
        exp_q.push_back(w);
      end
      k++;
      last = e;
      if (k == NUM) exp_fin = e + 1;
    end
    if (exp_fin < 0) begin
      exp_to  = last + TO;
      exp_fin = exp_to + 1;
    end

    for (int i = 0; i < n_drive; i++) begin
      repeat (g_gap[i]) begin
        @(negedge clk);
        in_dv = 1'b0;
        in_data = DW'($urandom);
      end
      @(negedge clk);
      in_dv = 1'b1;
      in_data = g_dat[i];
    end
    @(negedge clk);
    in_dv = 1'b0;
    budget = 0;
    while (!finish && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);

    tests++;
    if (finish !== 1'b1) begin
      fails++; $display("FAIL %s.finish_wait: finish=%b after %0d cycles, required 1", name, finish, budget);
    end
    tests++;
    if (fin_edge !== exp_fin) begin
      fails++; $display("FAIL %s.finish_edge: got %0d required %0d", name, fin_edge, exp_fin);
    end
    tests++;
    if (to_edge !== exp_to) begin
      fails++; $display("FAIL %s.timeout_edge: got %0d required %0d", name, to_edge, exp_to);
    end
    tests++;
    if (timeout !== (exp_to >= 0)) begin
      fails++; $display("FAIL %s.timeout: got %b required %b", name, timeout, exp_to >= 0);
    end
    tests++;
    if (overflow !== exp_ovf) begin
      fails++; $display("FAIL %s.overflow: got %b required %b", name, overflow, exp_ovf);
    end
    tests++;
    if (word_count !== (AW+1)'(k)) begin
      fails++; $display("FAIL %s.word_count: got %0d required %0d", name, word_count, k);
    end
    tests++;
    if (wr_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s.write_count: got %0d required %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      tests++;
      if (wr_q[i].e !== exp_q[i].e || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
        fails++;
        $display("FAIL %s.write%0d: got edge %0d addr %h data %h required edge %0d addr %h data %h",
                 name, i, wr_q[i].e, wr_q[i].a, wr_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    tests++;
    if (ocm1_write !== 1'b0 || ocm1_chip !== 1'b0 || ocm1_clk_enab !== 1'b0) begin
      fails++; $display("FAIL %s.done_strobes: got %b%b%b required 000", name, ocm1_write, ocm1_chip, ocm1_clk_enab);
    end

    hold_ovf = overflow;
    hold_to  = timeout;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (finish !== 1'b0 || word_count !== '0 || ocm1_addr !== '0 || ocm1_write !== 1'b0) begin
      fails++;
      $display("FAIL %s.idle_return: got finish=%b count=%0d addr=%h write=%b required all 0",
               name, finish, word_count, ocm1_addr, ocm1_write);
    end
    tests++;
    if (overflow !== hold_ovf || timeout !== hold_to) begin
      fails++; $display("FAIL %s.flags_hold: got %b%b required %b%b", name, overflow, timeout, hold_ovf, hold_to);
    end
  endtask

  task automatic test_reset();
    logic [48:0] v;
    reset = 1'b1; start = 1'b0; in_dv = 1'b0; in_data = '0;
    #12;
    v = {finish, ocm1_addr, ocm1_writedata, ocm1_chip, ocm1_clk_enab, ocm1_write, word_count, overflow, timeout};
    tests++;
    if (v !== '0) begin
      fails++; $display("FAIL reset.outputs: got %h required 0", v);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    v = {finish, ocm1_addr, ocm1_writedata, ocm1_chip, ocm1_clk_enab, ocm1_write, word_count, overflow, timeout};
    tests++;
    if (v !== '0) begin
      fails++; $display("FAIL reset.idle_outputs: got %h required 0", v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      g_gap[i] = 0;
      g_dat[i] = DW'((i + 1) * 8'h11);
    end
    run_stream(4, "back_to_back");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) begin
      g_gap[i] = 5;
      g_dat[i] = DW'($urandom);
    end
    run_stream(4, "gapped");
  endtask

  task automatic test_timeout();
    g_gap[0] = 0; g_dat[0] = 8'hA5;
    g_gap[1] = 1; g_dat[1] = 8'h5A;
    run_stream(2, "timeout");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      g_gap[i] = 0;
      g_dat[i] = DW'(8'hC0 + i);
    end
    run_stream(5, "overflow");
  endtask

  task automatic test_coincidence();
    g_gap[0] = 0; g_dat[0] = 8'h01;
    g_gap[1] = 7; g_dat[1] = 8'h02;
    g_gap[2] = 7; g_dat[2] = 8'h03;
    g_gap[3] = 0; g_dat[3] = 8'h04;
    run_stream(4, "coincidence");
  endtask

  task automatic test_reset_midrun();
    logic [48:0] v;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    in_dv = 1'b1; in_data = 8'h77;
    @(negedge clk);
    in_data = 8'h88;
    @(negedge clk);
    in_dv = 1'b0;
    tests++;
    if (ocm1_write !== 1'b1 || word_count !== (AW+1)'(2)) begin
      fails++; $display("FAIL reset_mid.pre: got write=%b count=%0d required 1 and 2", ocm1_write, word_count);
    end
    #2 reset = 1'b1;
    #1;
    v = {finish, ocm1_addr, ocm1_writedata, ocm1_chip, ocm1_clk_enab, ocm1_write, word_count, overflow, timeout};
    tests++;
    if (v !== '0) begin
      fails++; $display("FAIL reset_mid.async: got %h required 0", v);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g_gap[i] = i % 2;
      g_dat[i] = DW'($urandom);
    end
    run_stream(4, "after_reset");
  endtask

  task automatic test_random();
    int n, r;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 19);
        if (r < 12)      g_gap[i] = $urandom_range(0, 2);
        else if (r < 17) g_gap[i] = $urandom_range(3, TO - 1);
        else             g_gap[i] = $urandom_range(TO, TO + 2);
        g_dat[i] = DW'($urandom);
      end
      run_stream(n, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_timeout();
    test_overflow();
    test_coincidence();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
